meas_ctrl_mc: RTL
=================

Name: meas_ctrl_mc

Overview:
Multi-channel successor to the single-channel system controller for the phase-noise measurement path. It runs the IDLE/CONFIG/WAIT_FOR_START/EXE/FINISH sequencing and latches configuration: phase increment, capture length and mode. It gates NUM_CH sample streams, counts accepted samples per channel and ends a capture frame when every enabled channel has reached the programmed length. It adds continuous (auto-rearm) mode, early stop, a frame counter, and sticky error status with write-1-to-clear.

Parameters:
NUM_CH, 4, number of sample channels (1..16)
DATA_WIDTH, 32, sample and phase_inc width
MAX_CAPTURE, 1024, maximum samples per channel per frame; CNT_WIDTH = $clog2(MAX_CAPTURE+1)
CONFIG_DELAY, 3, cycles spent in CONFIG (>=1)
FRAME_CNT_WIDTH, 16, width of frame counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_config  in  1  config request pulse
phase_inc  in  DATA_WIDTH  phase increment, latched on accepted start_config
cfg_capture_len  in  CNT_WIDTH  samples per channel, latched on accepted start_config
cfg_mode  in  1  0 = single-shot, 1 = continuous; latched on accepted start_config
cfg_ch_en  in  NUM_CH  channel enable mask, latched on accepted start_config
start_op  in  1  start capture pulse
stop_op  in  1  early stop request
restart_vld  in  1  restart request
restart_type  in  2  0 REDO, 1 RECONFIG, 2 CLOSE, 3 reserved
in_data  in  NUM_CH*DATA_WIDTH  packed samples; ch i at [i*DATA_WIDTH +: DATA_WIDTH]
in_data_vld  in  NUM_CH  per-channel sample valid
err_clr  in  5  write-1-to-clear for err_status
out_data  out  NUM_CH*DATA_WIDTH  registered samples
out_data_vld  out  NUM_CH  registered per-channel valid
phase_inc_out  out  DATA_WIDTH  latched phase increment
clken  out  1  measurement clock enable
finish_op  out  1  high while in FINISH
frame_done  out  1  one-cycle pulse at end of each frame
frame_cnt  out  FRAME_CNT_WIDTH  completed frames since last accepted start_op
state  out  3  current state encoding
err_status  out  5  sticky error bits

Behaviour:
- Reset: state=IDLE (0). Outputs, counters, latched config and err_status are all 0.
- State encoding: IDLE=0, CONFIG=1, WAIT_FOR_START=2, EXE=3, FINISH=4.
- IDLE: start_config with 1<=cfg_capture_len<=MAX_CAPTURE and cfg_ch_en!=0 latches config and moves to CONFIG. Any other start_config stays in IDLE and sets err_status[4].
- CONFIG: stays exactly CONFIG_DELAY cycles, then WAIT_FOR_START.
- WAIT_FOR_START: start_op clears the per-channel counters and frame_cnt, then moves to EXE.
- EXE:
  - clken=1.
  - Channel i accepts a sample when in_data_vld[i] & cfg_ch_en[i] & cnt[i]<len. An accepted sample increments cnt[i].
  - A frame completes on the cycle where every enabled cnt will equal len after that cycle's update. On completion: frame_done pulses, frame_cnt increments (wraps), and the next state is FINISH (single-shot mode) or EXE with counters cleared (continuous mode).
  - stop_op in EXE goes to FINISH next cycle. No frame_done, frame_cnt unchanged. stop_op has priority over continuous rearm.
- FINISH: finish_op=1, clken=0. restart_vld with REDO goes to WAIT_FOR_START. RECONFIG goes to IDLE and keeps config. CLOSE goes to IDLE and clears phase_inc_out and config. Reserved type stays in FINISH and sets err_status[1].
- Datapath, 1-cycle latency: out_data[i] <= in_data[i] every cycle; out_data_vld[i] <= accept[i]. No sample is ever passed beyond len.
- err_status bits are set from the current state and inputs:
  - [0] start_op when not in WAIT_FOR_START
  - [1] restart_vld when not in FINISH, or reserved type
  - [2] start_config when not in IDLE
  - [3] any in_data_vld when not in EXE
  - [4] bad config
- err_status clear: a bit clears only when err_clr bit=1. If set and clear occur in the same cycle, set wins.
- Requests are ignored in every state other than their own (beyond the error bit): start_op, restart_vld and start_config outside their state do not change state.
- rst asserted mid-capture returns to the reset values on the next edge, including dropping any in-flight out_data_vld.

Test Plan:
- Reset, then start_config(len=4, ch_en=4'b0011, mode=0, phase_inc=0x1234), CONFIG_DELAY=3, start_op, continuous vld=4'b1111 → exactly 4 out_data_vld pulses on ch0/ch1 and none on ch2/ch3; frame_done=1 once; FINISH; frame_cnt=1; phase_inc_out=0x1234.
- Unequal rates: ch0 valid every cycle, ch1 every 3rd cycle, len=2 → FINISH only after ch1's 2nd sample; ch0 has exactly 2 pulses.
- Continuous mode, len=3, 5 frames → frame_done pulses 5 times; no FINISH; then stop_op → FINISH; frame_cnt=5.
- start_config with len=0 → stays IDLE, err_status=5'b10000; err_clr=5'b10000 with a simultaneous bad start_config → bit stays 1.
- From FINISH: REDO → WAIT_FOR_START with config kept; CLOSE → IDLE with phase_inc_out=0; restart_type=3 → stays FINISH with err_status[1]=1; start_op in IDLE → err_status[0]=1 and no state change.
- rst pulse mid-EXE (cnt=2 of 4) → state=0, all outputs 0; a new config and start captures a full 4 samples.

Source files
------------

// File: rtl/meas_ctrl_mc.sv
// Multi-channel measurement-path controller: IDLE/CONFIG/WAIT_FOR_START/EXE/FINISH
// sequencing, per-channel capture gating, continuous rearm, frame counting and sticky errors.
module meas_ctrl_mc #(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_CAPTURE     = 1024,
  parameter int unsigned CONFIG_DELAY    = 3,
  parameter int unsigned FRAME_CNT_WIDTH = 16,
  localparam int unsigned CNT_WIDTH      = $clog2(MAX_CAPTURE + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_config,
  input  logic [DATA_WIDTH-1:0]          phase_inc,
  input  logic [CNT_WIDTH-1:0]           cfg_capture_len,
  input  logic                           cfg_mode,
  input  logic [NUM_CH-1:0]              cfg_ch_en,
  input  logic                           start_op,
  input  logic                           stop_op,
  input  logic                           restart_vld,
  input  logic [1:0]                     restart_type,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_CH-1:0]              in_data_vld,
  input  logic [4:0]                     err_clr,
  output logic [NUM_CH*DATA_WIDTH-1:0]   out_data,
  output logic [NUM_CH-1:0]              out_data_vld,
  output logic [DATA_WIDTH-1:0]          phase_inc_out,
  output logic                           clken,
  output logic                           finish_op,
  output logic                           frame_done,
  output logic [FRAME_CNT_WIDTH-1:0]     frame_cnt,
  output logic [2:0]                     state,
  output logic [4:0]                     err_status
);

  localparam int unsigned CFG_W = (CONFIG_DELAY < 2) ? 1 : $clog2(CONFIG_DELAY);
  localparam logic [CFG_W-1:0]           DLY_LAST = CFG_W'(CONFIG_DELAY - 1);
  localparam logic [CFG_W-1:0]           DLY_ONE  = CFG_W'(1);
  localparam logic [CNT_WIDTH-1:0]       MAX_LEN  = CNT_WIDTH'(MAX_CAPTURE);
  localparam logic [CNT_WIDTH-1:0]       CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [FRAME_CNT_WIDTH-1:0] FCNT_ONE = FRAME_CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONFIG = 3'd1,
    S_WAIT   = 3'd2,
    S_EXE    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [CFG_W-1:0]           dly_q, dly_d;
  logic [DATA_WIDTH-1:0]      phase_q, phase_d;
  logic [CNT_WIDTH-1:0]       len_q, len_d;
  logic                       mode_q, mode_d;
  logic [NUM_CH-1:0]          en_q, en_d;
  logic [CNT_WIDTH-1:0]       cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0]       cnt_d [NUM_CH];
  logic [FRAME_CNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic                       fdone_q, fdone_d;
  logic [NUM_CH*DATA_WIDTH-1:0] odata_q;
  logic [NUM_CH-1:0]          ovld_q;
  logic [4:0]                 err_q, err_set;
  logic [NUM_CH-1:0]          accept;
  logic                       all_done;
  logic                       cfg_ok;

  assign cfg_ok = (cfg_capture_len != '0) && (cfg_capture_len <= MAX_LEN) && (|cfg_ch_en);

  // Completion looks at the post-update count so the frame ends on the last accepted sample.
  always_comb begin
    all_done = 1'b1;
    accept   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      accept[i] = (state_q == S_EXE) && in_data_vld[i] && en_q[i] && (cnt_q[i] < len_q);
      if (en_q[i] && ((accept[i] ? cnt_q[i] + CNT_ONE : cnt_q[i]) != len_q)) begin
        all_done = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    phase_d = phase_q;
    len_d   = len_q;
    mode_d  = mode_q;
    en_d    = en_q;
    fcnt_d  = fcnt_q;
    fdone_d = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = accept[i] ? cnt_q[i] + CNT_ONE : cnt_q[i];
    end
    unique case (state_q)
      S_IDLE: begin
        if (start_config && cfg_ok) begin
          phase_d = phase_inc;
          len_d   = cfg_capture_len;
          mode_d  = cfg_mode;
          en_d    = cfg_ch_en;
          dly_d   = '0;
          state_d = S_CONFIG;
        end
      end
      S_CONFIG: begin
        if (dly_q == DLY_LAST) state_d = S_WAIT;
        else                   dly_d   = dly_q + DLY_ONE;
      end
      S_WAIT: begin
        if (start_op) begin
          for (int unsigned i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
          fcnt_d  = '0;
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (stop_op) begin
          state_d = S_FINISH;
        end else if (all_done) begin
          fdone_d = 1'b1;
          fcnt_d  = fcnt_q + FCNT_ONE;
          if (mode_q) begin
            for (int unsigned i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        if (restart_vld) begin
          case (restart_type)
            2'd0: state_d = S_WAIT;
            2'd1: state_d = S_IDLE;
            2'd2: begin
              state_d = S_IDLE;
              phase_d = '0;
              len_d   = '0;
              mode_d  = 1'b0;
              en_d    = '0;
            end
            default: state_d = S_FINISH;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    err_set    = '0;
    err_set[0] = start_op && (state_q != S_WAIT);
    err_set[1] = restart_vld && ((state_q != S_FINISH) || (restart_type == 2'd3));
    err_set[2] = start_config && (state_q != S_IDLE);
    err_set[3] = (|in_data_vld) && (state_q != S_EXE);
    err_set[4] = start_config && (state_q == S_IDLE) && !cfg_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dly_q   <= '0;
      phase_q <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      en_q    <= '0;
      fcnt_q  <= '0;
      fdone_q <= 1'b0;
      odata_q <= '0;
      ovld_q  <= '0;
      err_q   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      phase_q <= phase_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      fcnt_q  <= fcnt_d;
      fdone_q <= fdone_d;
      odata_q <= in_data;
      ovld_q  <= accept;
      err_q   <= (err_q & ~err_clr) | err_set;
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_data      = odata_q;
  assign out_data_vld  = ovld_q;
  assign phase_inc_out = phase_q;
  assign clken         = (state_q == S_EXE);
  assign finish_op     = (state_q == S_FINISH);
  assign frame_done    = fdone_q;
  assign frame_cnt     = fcnt_q;
  assign state         = state_q;
  assign err_status    = err_q;

endmodule
